// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO architectural register stage behind the combinational mult/div unit.
//
// A MULT/MULTU/DIV/DIVU issue latches the HI/LO results immediately. They are then held
// pending for a fixed per-class latency, which models a multi-cycle MDU, and committed
// into the architectural HI/LO registers. MFHI/MFLO reads, MTHI/MTLO writes and new issues
// are stalled while a result is pending. A flush cancels the pending operation.
//
// Optional feature: define HILO_BYPASS_EN to forward the pending result onto hi_o/lo_o
// during the commit cycle. In that cycle a read proceeds without stalling.
//
// Parameters:
//   MUL_LAT   busy cycles for MULT/MULTU (1..15)
//   DIV_LAT   busy cycles for DIV/DIVU   (1..15)
//
// Ports:
//   clk       clock, rising edge
//   resetn    asynchronous active-low reset
//   start_i   mult/div issues this cycle; hi_i/lo_i valid
//   is_div_i  1 = divide class (DIV_LAT), 0 = multiply class (MUL_LAT)
//   hi_i      HI result from the mult/div unit
//   lo_i      LO result from the mult/div unit
//   mthi_i    MTHI write request
//   mtlo_i    MTLO write request
//   wdata_i   MTHI/MTLO write data
//   rd_i      MFHI/MFLO read request
//   flush_i   cancel any pending operation (highest priority)
//   hi_o      architectural HI
//   lo_o      architectural LO
//   busy_o    an operation is pending
//   stall_o   requester must hold its instruction this cycle
module hilo_unit #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic        is_div_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        mthi_i,
  input  logic        mtlo_i,
  input  logic [31:0] wdata_i,
  input  logic        rd_i,
  input  logic        flush_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o,
  output logic        stall_o
);

  // The counter is loaded with LAT-1, so the last busy cycle is the one with cnt == 0.
  localparam logic [3:0] MulCnt = 4'(MUL_LAT - 1);
  localparam logic [3:0] DivCnt = 4'(DIV_LAT - 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        commit;

  // Final busy cycle, not cancelled by a flush.
  assign commit = (state_q == StBusy) && (cnt_q == 4'd0) && !flush_i;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    if (flush_i) begin
      // Pending result is dropped; same-cycle issue and MT writes are ignored.
      state_d = StIdle;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            // An issue takes precedence over a simultaneous MT write.
            pend_hi_d = hi_i;
            pend_lo_d = lo_i;
            cnt_d     = is_div_i ? DivCnt : MulCnt;
            state_d   = StBusy;
          end else begin
            if (mthi_i) hi_d = wdata_i;
            if (mtlo_i) lo_d = wdata_i;
          end
        end
        StBusy: begin
          // Requests arriving while busy are stalled and have no effect.
          if (commit) begin
            hi_d    = pend_hi_q;
            lo_d    = pend_lo_q;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy_o = (state_q == StBusy);
    hi_o   = hi_q;
    lo_o   = lo_q;
`ifdef HILO_BYPASS_EN
    if (commit) begin
      hi_o = pend_hi_q;
      lo_o = pend_lo_q;
    end
    // A read in the commit cycle sees the forwarded value, so it does not stall.
    stall_o = busy_o & ((rd_i & ~commit) | mthi_i | mtlo_i | start_i);
`else
    stall_o = busy_o & (rd_i | mthi_i | mtlo_i | start_i);
`endif
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Testbench for hilo_unit at its default latencies (MUL_LAT=3, DIV_LAT=8).
// Per-cycle directed vectors: inputs are driven after the falling edge and outputs are
// checked 1 ns later, before the next rising edge.
module tb_hilo_unit;

`ifdef HILO_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  typedef struct {
    logic        start;
    logic        is_div;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        rd;
    logic        flush;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    logic        exp_busy;
    logic        exp_stall;
  } vec_t;

  logic        clk;
  logic        resetn;
  logic        start_i;
  logic        is_div_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        mthi_i;
  logic        mtlo_i;
  logic [31:0] wdata_i;
  logic        rd_i;
  logic        flush_i;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy_o;
  logic        stall_o;

  int total;
  int bad;
  vec_t vecs[$];

  hilo_unit dut (
    .clk      (clk),
    .resetn   (resetn),
    .start_i  (start_i),
    .is_div_i (is_div_i),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .mthi_i   (mthi_i),
    .mtlo_i   (mtlo_i),
    .wdata_i  (wdata_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .hi_o     (hi_o),
    .lo_o     (lo_o),
    .busy_o   (busy_o),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic push(input logic st, input logic dv, input logic [31:0] h, input logic [31:0] l,
                      input logic mh, input logic ml, input logic [31:0] wd, input logic rd,
                      input logic fl, input logic [31:0] eh, input logic [31:0] el,
                      input logic eb, input logic es);
    vec_t v;
    v.start = st; v.is_div = dv; v.hi = h; v.lo = l; v.mthi = mh; v.mtlo = ml;
    v.wdata = wd; v.rd = rd; v.flush = fl;
    v.exp_hi = eh; v.exp_lo = el; v.exp_busy = eb; v.exp_stall = es;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; is_div_i = 1'b0; hi_i = '0; lo_i = '0;
    mthi_i = 1'b0; mtlo_i = 1'b0; wdata_i = '0; rd_i = 1'b0; flush_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    resetn = 1'b0;

    // --- IDLE MT writes ---
    push(0,0,0,0, 0,0,0,0,0, 32'h0,        32'h0,        0,0); // reset state
    push(0,0,0,0, 1,0,32'hDEADBEEF,0,0, 32'h0, 32'h0,    0,0); // MTHI
    push(0,0,0,0, 0,0,0,0,0, 32'hDEADBEEF, 32'h0,        0,0); // HI written, LO unchanged
    push(0,0,0,0, 0,1,32'h12345678,0,0, 32'hDEADBEEF, 32'h0, 0,0); // MTLO
    push(0,0,0,0, 1,1,32'hA5A5A5A5,0,0, 32'hDEADBEEF, 32'h12345678, 0,0); // both
    // --- MULT with simultaneous MTLO (dropped), MT/read while busy ---
    push(1,0,32'h1,32'hFFFFFFFE, 0,1,32'h0BAD0BAD,0,0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0,0);
    push(0,0,0,0, 0,0,0,0,0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1,0);              // cycle 1
    push(0,0,0,0, 1,0,32'h11111111,0,0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1,1);   // cycle 2 MTHI
    push(0,0,0,0, 0,0,0,1,0, Byp ? 32'h1 : 32'hA5A5A5A5,
         Byp ? 32'hFFFFFFFE : 32'hA5A5A5A5, 1, !Byp);                       // cycle 3 read
    push(0,0,0,0, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 0,0);                      // cycle 4
    push(0,0,0,0, 0,0,0,1,0, 32'h1, 32'hFFFFFFFE, 0,0);                      // idle read
    // --- DIV flushed in cycle 2, with a same-cycle start ignored ---
    push(1,1,32'hCAFE0001,32'hCAFE0002, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 0,0);
    push(0,0,0,0, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 1,0);
    push(1,0,32'h77,32'h88, 0,0,0,0,1, 32'h1, 32'hFFFFFFFE, 1,1);
    push(0,0,0,0, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 0,0);
    push(0,0,0,0, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 0,0);
    // --- MULT flushed in its commit cycle ---
    push(1,0,32'h2,32'h3, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 0,0);
    push(0,0,0,0, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 1,0);
    push(0,0,0,0, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 1,0);
    push(0,0,0,0, 0,0,0,0,1, 32'h1, 32'hFFFFFFFE, 1,0);
    push(0,0,0,0, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 0,0);
    // --- DIV with rd held from cycle 1, stray start in cycle 4 ---
    push(1,1,32'h44444444,32'h55555555, 0,0,0,0,0, 32'h1, 32'hFFFFFFFE, 0,0);
    for (int c = 1; c <= 7; c++) begin
      push(c == 4, 0, 32'h99, 32'h99, 0,0,0,1,0, 32'h1, 32'hFFFFFFFE, 1,1);
    end
    push(0,0,0,0, 0,0,0,1,0, Byp ? 32'h44444444 : 32'h1,
         Byp ? 32'h55555555 : 32'hFFFFFFFE, 1, !Byp);                       // cycle 8
    push(0,0,0,0, 0,0,0,1,0, 32'h44444444, 32'h55555555, 0,0);              // cycle 9
    // --- flush in IDLE blocks a same-cycle MTHI ---
    push(0,0,0,0, 1,0,32'h77777777,0,1, 32'h44444444, 32'h55555555, 0,0);
    push(0,0,0,0, 0,0,0,0,0, 32'h44444444, 32'h55555555, 0,0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) begin
      start_i = vecs[i].start; is_div_i = vecs[i].is_div;
      hi_i = vecs[i].hi; lo_i = vecs[i].lo;
      mthi_i = vecs[i].mthi; mtlo_i = vecs[i].mtlo; wdata_i = vecs[i].wdata;
      rd_i = vecs[i].rd; flush_i = vecs[i].flush;
      #1;
      check32($sformatf("v%0d hi_o", i), hi_o, vecs[i].exp_hi);
      check32($sformatf("v%0d lo_o", i), lo_o, vecs[i].exp_lo);
      check1($sformatf("v%0d busy_o", i), busy_o, vecs[i].exp_busy);
      check1($sformatf("v%0d stall_o", i), stall_o, vecs[i].exp_stall);
      @(negedge clk);
    end

    // --- asynchronous reset in the middle of a DIV ---
    start_i = 1'b1; is_div_i = 1'b1; hi_i = 32'h12340000; lo_i = 32'h00005678;
    @(negedge clk);
    idle_inputs();
    #1;
    check1("rst pre busy_o", busy_o, 1'b1);
    @(negedge clk);
    rd_i = 1'b1;
    resetn = 1'b0;
    #1;
    check1("rst busy_o", busy_o, 1'b0);
    check1("rst stall_o", stall_o, 1'b0);
    check32("rst hi_o", hi_o, 32'h0);
    check32("rst lo_o", lo_o, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    rd_i = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check1("post rst busy_o", busy_o, 1'b0);
    check32("post rst hi_o", hi_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
